wb_latency_ram: RTL

Pipelined Wishbone slave RAM that answers the platform's master-side Wishbone ports (instruction fetch, DMEM, DDR3 stand-in) with a configurable, fixed response latency, bounded outstanding requests and optional pseudo-random stall injection. It is the responder end of the pipelined Wishbone protocol driven by the core and crossbar. It is used as the simulation and FPGA-BRAM memory model behind any `wishbone_if.MASTER` port of the platform.

---
 rtl/wb_latency_ram_pkg.sv | 18 +
 rtl/wishbone_if.sv | 19 +
 rtl/wb_resp_pipe.sv | 28 ++
 rtl/wb_latency_ram.sv | 65 ++++++
 4 files changed

// File: rtl/wb_latency_ram_pkg.sv
// wb_latency_ram_pkg: shared Wishbone widths, response record and stall-LFSR step
//   WB_AW/WB_DW : address/data widths of the platform Wishbone bus
//   wb_resp_t   : one response-pipeline stage {valid, err, data}
//   LFSR_TAPS   : feedback mask for x^16+x^14+x^13+x^11+1 (left-shifting Fibonacci)
package wb_latency_ram_pkg;
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  typedef struct packed {
    logic valid;
    logic err;
    logic [WB_DW-1:0] data;
  } wb_resp_t;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/wishbone_if.sv
// wishbone_if: pipelined Wishbone bus bundle
//   master drives cyc, stb, we, addr (byte), wdata, sel
//   slave drives rdata, ack, err, stall, rty
interface wishbone_if;
  import wb_latency_ram_pkg::*;
  logic cyc;
  logic stb;
  logic we;
  logic [WB_AW-1:0] addr;
  logic [WB_DW-1:0] wdata;
  logic [WB_SW-1:0] sel;
  logic [WB_DW-1:0] rdata;
  logic ack;
  logic err;
  logic stall;
  logic rty;
  modport MASTER (output cyc, stb, we, addr, wdata, sel, input rdata, ack, err, stall, rty);
  modport SLAVE (input cyc, stb, we, addr, wdata, sel, output rdata, ack, err, stall, rty);
endinterface

// File: rtl/wb_resp_pipe.sv
// wb_resp_pipe: LATENCY-stage shift line of Wishbone responses with synchronous clear
//   clk_i : clock
//   clr_i : drops every valid on the next edge (reset or bus abort)
//   in_i  : response captured in the acceptance cycle (stage 0 input)
//   out_o : last stage, drives the bus response
module wb_resp_pipe
  import wb_latency_ram_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic     clk_i,
  input  logic     clr_i,
  input  wb_resp_t in_i,
  output wb_resp_t out_o
);
  wb_resp_t stage_q [LATENCY];
  wb_resp_t stage_d [LATENCY];
  always_comb begin
    stage_d[0] = in_i;
    stage_d[0].valid = in_i.valid & ~clr_i;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
      stage_d[i].valid = stage_q[i-1].valid & ~clr_i;
    end
  end
  always_ff @(posedge clk_i) stage_q <= stage_d;
  always_comb out_o = stage_q[LATENCY-1];
endmodule

// File: rtl/wb_latency_ram.sv
// wb_latency_ram: pipelined Wishbone slave RAM with fixed response latency and stall injection
//   clk_i  : clock
//   rstn_i : synchronous active-low reset
//   wb_if  : Wishbone slave port (byte addressed, 32-bit data, per-byte sel)
module wb_latency_ram
  import wb_latency_ram_pkg::*;
#(
  parameter logic [WB_AW-1:0] BASE_ADDR       = '0,
  parameter int               DEPTH_WORDS     = 1024,
  parameter int               LATENCY         = 2,
  parameter int               MAX_OUTSTANDING = 4,
  parameter bit               STALL_INJECT    = 1'b0,
  parameter logic [15:0]      LFSR_SEED       = 16'hACE1
) (
  input logic       clk_i,
  input logic       rstn_i,
  wishbone_if.SLAVE wb_if
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  logic [WB_DW-1:0] mem_q [DEPTH_WORDS];
  logic [WB_AW-1:0] off_w;
  logic [IW-1:0] idx;
  logic in_range, stall, accept, clr;
  logic [CW-1:0] outst_q, outst_d;
  logic [15:0] lfsr_q, lfsr_d;
  wb_resp_t req, last;
  // word offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range
  always_comb begin
    off_w = (wb_if.addr - BASE_ADDR) >> 2;
    idx = off_w[IW-1:0];
    in_range = off_w < WB_AW'(DEPTH_WORDS);
    // a same-cycle ack does not relieve the full condition
    stall = ~rstn_i | (outst_q == CW'(MAX_OUTSTANDING)) | (STALL_INJECT & lfsr_q[0]);
    accept = wb_if.cyc & wb_if.stb & ~stall;
    clr = ~rstn_i | ~wb_if.cyc;
    req.valid = accept;
    req.err = ~in_range;
    req.data = (~wb_if.we & in_range) ? mem_q[idx] : '0;
    outst_d = clr ? '0 : outst_q + CW'(accept) - CW'(last.valid);
    lfsr_d = STALL_INJECT ? lfsr_next(lfsr_q) : lfsr_q;
    wb_if.stall = stall;
    wb_if.ack = rstn_i & last.valid & ~last.err;
    wb_if.err = rstn_i & last.valid & last.err;
    wb_if.rdata = (rstn_i & last.valid) ? last.data : '0;
    wb_if.rty = 1'b0;
  end
  always_ff @(posedge clk_i)
    for (int b = 0; b < WB_SW; b++)
      if (accept & wb_if.we & in_range & wb_if.sel[b]) mem_q[idx][8*b +: 8] <= wb_if.wdata[8*b +: 8];
  always_ff @(posedge clk_i)
    if (!rstn_i) begin
      outst_q <= '0;
      lfsr_q <= LFSR_SEED;
    end else begin
      outst_q <= outst_d;
      lfsr_q <= lfsr_d;
    end
  wb_resp_pipe #(.LATENCY(LATENCY)) u_pipe (
    .clk_i(clk_i),
    .clr_i(clr),
    .in_i (req),
    .out_o(last)
  );
endmodule
